cpu_mem_bus: RTL and testbench
==============================

CPU_MEM_BUS -- requirements
Module: cpu_mem_bus

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, both listed below.
  clk  input  1  clock; all state updates on rising edge
  reset  input  1  synchronous, active-high reset
REQ-002 The block SHALL have the following request-side ports.
  t_cycle  input  2  T-cycle phase 0..3; one M-cycle = 4 clk
  mem_enable  input  1  CPU requests an access this M-cycle
  mem_write  input  1  1 = write, 0 = read (valid with mem_enable)
  mem_addr  input  16  CPU address
  mem_data_write  input  8  CPU write data
  mem_data_read  output  8  read data returned to the CPU
REQ-003 The block SHALL have the following external-bus, DMA and interrupt ports.
  ext_addr  output  16  external bus address
  ext_rd  output  1  external read strobe
  ext_wr  output  1  external write strobe
  ext_data_out  output  8  external write data
  ext_data_in  input  8  external read data
  dma_active  input  1  OAM DMA in progress; external bus unavailable to the CPU
  ie_out  output  5  IE register bits [4:0], to the interrupt controller

Function
REQ-004 The request (mem_enable, mem_write, mem_addr, mem_data_write, dma_active) SHALL be latched on the rising edge ending t_cycle==0.
- Request inputs SHALL be ignored at all other phases.
REQ-005 The address decode of the latched mem_addr SHALL be:
- 0xFF80-0xFFFE: HRAM (127x8 internal array)
- 0xFFFF: IE (8-bit register)
- all other addresses: EXT
REQ-006 The FSM SHALL have states IDLE, ADDR, DATA, DONE.
- From IDLE: go to ADDR on the edge ending t_cycle 0 if the latched mem_enable=1; otherwise stay in IDLE.
- ADDR -> DATA on the edge ending t_cycle 1.
- DATA -> DONE on the edge ending t_cycle 2.
- DONE -> IDLE on the edge ending t_cycle 3.
REQ-007 An internal read (HRAM/IE) SHALL load mem_data_read on the edge ending t_cycle 1.
REQ-008 An EXT read with latched dma_active=0 SHALL behave as follows:
- ext_rd=1 during t_cycle 1 and 2.
- ext_addr = latched address.
- ext_data_in is sampled into mem_data_read on the edge ending t_cycle 2.
REQ-009 An EXT write with latched dma_active=0 SHALL behave as follows:
- ext_wr=1 during t_cycle 2 only.
- ext_addr and ext_data_out hold the latched values from t_cycle 1 through t_cycle 3.
REQ-010 An internal write SHALL commit to HRAM/IE on the edge ending t_cycle 2.
REQ-011 An EXT access with latched dma_active=1 SHALL produce no strobes.
- A read SHALL return 0xFF, loaded on the edge ending t_cycle 2.
- A write SHALL be dropped.
- HRAM/IE accesses SHALL be unaffected by dma_active.
REQ-012 mem_data_read SHALL be stable and valid throughout t_cycle 3 of every read M-cycle.
REQ-013 mem_data_read SHALL hold its previous value across write M-cycles and idle M-cycles.
REQ-014 ext_rd and ext_wr SHALL never be asserted simultaneously.
- Both SHALL be 0 in IDLE and DONE.
REQ-015 A read of IE SHALL return all 8 bits as last written.
- ie_out SHALL equal IE[4:0] continuously.
REQ-016 A read of an HRAM address SHALL return the last value written to that address; HRAM reads have no side effects.
REQ-017 A write followed by a read of the same address in the next M-cycle SHALL return the new value (no hazard, since the write commits before the next t_cycle 1).
REQ-018 If t_cycle jumps out of sequence, the FSM SHALL return to IDLE on the next edge with t_cycle==3.
- Any pending write SHALL be discarded.

Reset
REQ-019 Reset SHALL set the following values:
- mem_data_read=0xFF, ext_rd=0, ext_wr=0, ext_addr=0x0000, ext_data_out=0x00
- IE=0x00 (ie_out=0), FSM=IDLE
REQ-020 HRAM contents SHALL NOT be reset.
REQ-021 Reset asserted mid-access SHALL behave as follows:
- Strobes deassert on the same edge.
- A pending write is discarded.
- Normal operation resumes at the first t_cycle 0 after reset deasserts.

Verification
REQ-022 HRAM write then read: write 0x5A to 0xFF90, next M-cycle read 0xFF90 -> mem_data_read=0x5A during t_cycle 3, ext_rd/ext_wr never asserted.
REQ-023 IE write then read: write 0xE3 to 0xFFFF -> ie_out=0x03; read 0xFFFF -> 0xE3.
REQ-024 EXT read: read 0xC123 with ext_data_in=0x77 -> ext_addr=0xC123, ext_rd high exactly in t_cycle 1-2, mem_data_read=0x77 at t_cycle 3.
REQ-025 EXT write during DMA: dma_active=1, write 0x11 to 0x8000 -> no ext_wr; EXT read during DMA -> 0xFF; same M-cycle pattern to 0xFF80 -> succeeds.
REQ-026 Reset mid-write: assert reset during t_cycle 1 of an EXT write to 0xA000 -> ext_wr never pulses, mem_data_read=0xFF, ie_out=0.
REQ-027 Idle M-cycle after a read of 0x42: mem_enable=0 -> mem_data_read stays 0x42, no strobes.

Source files
------------

// File: rtl/cpu_mem_bus.sv
// CPU-side memory bus controller: sequences one access per 4-clk M-cycle to HRAM,
// the IE register or the external bus, with OAM DMA blocking of external accesses.
module cpu_mem_bus (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  t_cycle,
    input  logic        mem_enable,
    input  logic        mem_write,
    input  logic [15:0] mem_addr,
    input  logic [7:0]  mem_data_write,
    output logic [7:0]  mem_data_read,
    output logic [15:0] ext_addr,
    output logic        ext_rd,
    output logic        ext_wr,
    output logic [7:0]  ext_data_out,
    input  logic [7:0]  ext_data_in,
    input  logic        dma_active,
    output logic [4:0]  ie_out
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t      state;
    logic        req_write;
    logic        req_dma;
    logic [15:0] req_addr;
    logic [7:0]  req_data;
    logic [7:0]  ie_reg;
    logic [7:0]  hram [0:126];

    logic in_ext;
    logic req_ie;
    logic req_hram;
    logic req_ext;

    assign in_ext   = (mem_addr < 16'hFF80);
    assign req_ie   = (req_addr == 16'hFFFF);
    assign req_ext  = (req_addr < 16'hFF80);
    assign req_hram = !req_ext && !req_ie;
    assign ie_out   = ie_reg[4:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            req_write <= 1'b0;
            req_dma   <= 1'b0;
            req_addr  <= 16'h0000;
            req_data  <= 8'h00;
        end else if (t_cycle == 2'd0) begin
            req_write <= mem_write;
            req_dma   <= dma_active;
            req_addr  <= mem_addr;
            req_data  <= mem_data_write;
        end
    end

    // Phase mismatch parks the FSM in DONE: no strobes, no commit, exit at t_cycle 3.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            mem_data_read <= 8'hFF;
            ext_rd        <= 1'b0;
            ext_wr        <= 1'b0;
            ext_addr      <= 16'h0000;
            ext_data_out  <= 8'h00;
            ie_reg        <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (t_cycle == 2'd0 && mem_enable) begin
                        state <= ADDR;
                        if (in_ext && !dma_active) begin
                            ext_addr <= mem_addr;
                            if (mem_write)
                                ext_data_out <= mem_data_write;
                            else
                                ext_rd <= 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (t_cycle == 2'd1) begin
                        state <= DATA;
                        if (!req_write && !req_ext)
                            mem_data_read <= req_ie ? ie_reg : hram[req_addr[6:0]];
                        if (req_write && req_ext && !req_dma)
                            ext_wr <= 1'b1;
                    end else begin
                        state  <= (t_cycle == 2'd3) ? IDLE : DONE;
                        ext_rd <= 1'b0;
                    end
                end
                DATA: begin
                    ext_rd <= 1'b0;
                    ext_wr <= 1'b0;
                    if (t_cycle == 2'd2) begin
                        state <= DONE;
                        if (!req_write && req_ext)
                            mem_data_read <= req_dma ? 8'hFF : ext_data_in;
                        if (req_write && req_ie)
                            ie_reg <= req_data;
                    end else begin
                        state <= (t_cycle == 2'd3) ? IDLE : DONE;
                    end
                end
                DONE: begin
                    if (t_cycle == 2'd3)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // HRAM is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!reset && state == DATA && t_cycle == 2'd2 && req_write && req_hram)
            hram[req_addr[6:0]] <= req_data;
    end

endmodule

// File: tb/tb_cpu_mem_bus.sv
// Directed bench for cpu_mem_bus: drives whole M-cycles and checks strobes per phase
// and read data at t_cycle 3 against hand-computed values.
module tb_cpu_mem_bus;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  t_cycle;
    logic        mem_enable;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data_write;
    logic [7:0]  mem_data_read;
    logic [15:0] ext_addr;
    logic        ext_rd;
    logic        ext_wr;
    logic [7:0]  ext_data_out;
    logic [7:0]  ext_data_in;
    logic        dma_active;
    logic [4:0]  ie_out;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0]  rd_mask;
    logic [3:0]  wr_mask;
    logic [7:0]  rdata3;
    logic [15:0] addr1;
    logic [7:0]  dout2;
    logic        wr_seen;

    cpu_mem_bus dut (
        .clk            (clk),
        .reset          (reset),
        .t_cycle        (t_cycle),
        .mem_enable     (mem_enable),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_data_write (mem_data_write),
        .mem_data_read  (mem_data_read),
        .ext_addr       (ext_addr),
        .ext_rd         (ext_rd),
        .ext_wr         (ext_wr),
        .ext_data_out   (ext_data_out),
        .ext_data_in    (ext_data_in),
        .dma_active     (dma_active),
        .ie_out         (ie_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // One full M-cycle; request inputs are scrambled outside phase 0.
    task automatic mcycle(input logic en, input logic wr, input logic [15:0] addr,
                          input logic [7:0] wdata, input logic dma, input logic [7:0] ein);
        ext_data_in = ein;
        for (int p = 0; p < 4; p++) begin
            t_cycle = 2'(p);
            if (p == 0) begin
                mem_enable     = en;
                mem_write      = wr;
                mem_addr       = addr;
                mem_data_write = wdata;
                dma_active     = dma;
            end else begin
                mem_enable     = 1'b1;
                mem_write      = ~wr;
                mem_addr       = 16'hFFFF;
                mem_data_write = 8'h00;
                dma_active     = ~dma;
            end
            @(negedge clk);
            rd_mask[p] = ext_rd;
            wr_mask[p] = ext_wr;
            if (p == 1) addr1 = ext_addr;
            if (p == 2) dout2 = ext_data_out;
            if (p == 3) rdata3 = mem_data_read;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; t_cycle = 2'd0; mem_enable = 1'b0; mem_write = 1'b0;
        mem_addr = 16'h0000; mem_data_write = 8'h00; ext_data_in = 8'h00; dma_active = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdata", 16'(mem_data_read), 16'h00FF);
        chk("rst_strobes", {14'h0, ext_rd, ext_wr}, 16'h0000);
        chk("rst_ext_addr", ext_addr, 16'h0000);
        chk("rst_ext_dout", 16'(ext_data_out), 16'h0000);
        chk("rst_ie", 16'(ie_out), 16'h0000);
        @(posedge clk); #1;
        reset = 1'b0;

        // HRAM write then read
        mcycle(1, 1, 16'hFF90, 8'h5A, 0, 8'h00);
        chk("hram_wr_strobes", {8'h0, rd_mask, wr_mask}, 16'h0000);
        mcycle(1, 0, 16'hFF90, 8'h00, 0, 8'h00);
        chk("hram_rd_data", 16'(rdata3), 16'h005A);
        chk("hram_rd_strobes", {8'h0, rd_mask, wr_mask}, 16'h0000);

        // IE write then read
        mcycle(1, 1, 16'hFFFF, 8'hE3, 0, 8'h00);
        chk("ie_out", 16'(ie_out), 16'h0003);
        mcycle(1, 0, 16'hFFFF, 8'h00, 0, 8'h00);
        chk("ie_rd_data", 16'(rdata3), 16'h00E3);

        // EXT read
        mcycle(1, 0, 16'hC123, 8'h00, 0, 8'h77);
        chk("ext_rd_addr", addr1, 16'hC123);
        chk("ext_rd_mask", 16'(rd_mask), 16'h0006);
        chk("ext_rd_wrmask", 16'(wr_mask), 16'h0000);
        chk("ext_rd_data", 16'(rdata3), 16'h0077);

        // EXT write, read data must hold
        mcycle(1, 1, 16'h4000, 8'h3C, 0, 8'h00);
        chk("ext_wr_mask", 16'(wr_mask), 16'h0004);
        chk("ext_wr_rdmask", 16'(rd_mask), 16'h0000);
        chk("ext_wr_addr", addr1, 16'h4000);
        chk("ext_wr_dout", 16'(dout2), 16'h003C);
        chk("ext_wr_hold_rdata", 16'(rdata3), 16'h0077);

        // DMA blocks EXT but not HRAM
        mcycle(1, 1, 16'h8000, 8'h11, 1, 8'h00);
        chk("dma_wr_strobes", {8'h0, rd_mask, wr_mask}, 16'h0000);
        mcycle(1, 0, 16'h8000, 8'h00, 1, 8'h55);
        chk("dma_rd_data", 16'(rdata3), 16'h00FF);
        chk("dma_rd_strobes", {8'h0, rd_mask, wr_mask}, 16'h0000);
        mcycle(1, 1, 16'hFF80, 8'hAB, 1, 8'h00);
        mcycle(1, 0, 16'hFF80, 8'h00, 1, 8'h00);
        chk("dma_hram_rd", 16'(rdata3), 16'h00AB);

        // Idle M-cycle after a read of 0x42
        mcycle(1, 0, 16'h1000, 8'h00, 0, 8'h42);
        chk("pre_idle_rd", 16'(rdata3), 16'h0042);
        mcycle(0, 0, 16'h1000, 8'h00, 0, 8'h99);
        chk("idle_hold", 16'(rdata3), 16'h0042);
        chk("idle_strobes", {8'h0, rd_mask, wr_mask}, 16'h0000);

        // Out-of-sequence phase drops a pending HRAM write
        t_cycle = 2'd0; mem_enable = 1'b1; mem_write = 1'b1; mem_addr = 16'hFF90;
        mem_data_write = 8'h77; dma_active = 1'b0;
        @(posedge clk); #1;
        t_cycle = 2'd1; mem_enable = 1'b0;
        @(posedge clk); #1;
        t_cycle = 2'd0;
        @(posedge clk); #1;
        t_cycle = 2'd3;
        @(posedge clk); #1;
        mcycle(1, 0, 16'hFF90, 8'h00, 0, 8'h00);
        chk("oos_write_dropped", 16'(rdata3), 16'h005A);

        // Reset during t_cycle 1 of an EXT write
        t_cycle = 2'd0; mem_enable = 1'b1; mem_write = 1'b1; mem_addr = 16'hA000;
        mem_data_write = 8'h99; dma_active = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        wr_seen = 1'b0;
        for (int p = 1; p < 4; p++) begin
            t_cycle = 2'(p);
            @(negedge clk);
            wr_seen = wr_seen | ext_wr;
            @(posedge clk); #1;
        end
        reset = 1'b0;
        mcycle(0, 0, 16'h0000, 8'h00, 0, 8'h00);
        chk("rstmid_no_wr", {15'h0, wr_seen | (|wr_mask)}, 16'h0000);
        chk("rstmid_rdata", 16'(rdata3), 16'h00FF);
        chk("rstmid_ie", 16'(ie_out), 16'h0000);
        chk("rstmid_ext_addr", ext_addr, 16'h0000);
        mcycle(1, 0, 16'hFF90, 8'h00, 0, 8'h00);
        chk("hram_survives_rst", 16'(rdata3), 16'h005A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
